axi_regfile_param: RTL
======================

# axi_regfile_param

Parametrised AXI4-Lite slave register file between the PS general-purpose AXI master and PL logic. Provides NREG control registers (written by software, driven to fabric) and per-register read-back selection: each register reads back either its own stored value or a fabric-driven status word. Adds byte-strobe writes, address decode errors, and one-cycle write/read pulses per register, so fabric can implement command and clear-on-read registers.

## Interface
- NREG, 16: number of registers, 1..256
- DATA_W, 32: register and AXI data width, 32 or 64
- ADDR_W, 12: AXI byte-address width; must be at least log2(NREG) + log2(DATA_W/8)
- RO_MASK, all 0 (NREG bits): bit i = 1 means reads of register i return reg_in[i]; writes to it are discarded
- axi_aclk  in  1  sole clock
- axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read data channel
- reg_out  out  NREG*DATA_W  stored register values; register i is at [i*DATA_W +: DATA_W]
- reg_in  in  NREG*DATA_W  status words, used for RO_MASK registers
- wr_pulse  out  NREG  one-cycle strobe after a committed write to register i
- rd_pulse  out  NREG  one-cycle strobe after a read of register i

## Operation
- Word index = addr >> log2(DATA_W/8). Low address bits are ignored. If index ≥ NREG, the access is out of range.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, awready = !aw_held and wready = !w_held. AW and W are accepted independently, in either order or in the same cycle, and each is latched.
  - At the edge where both address and data are available (held or handshaking that cycle), the write commits and the FSM moves to W_RESP.
- Commit:
  - In range and RO_MASK[i] = 0: each byte b with wstrb[b] = 1 is written into reg_out[i]. wr_pulse[i] is high for the next cycle. bresp = OKAY.
  - In range and RO_MASK[i] = 1: no register change and no wr_pulse. bresp = OKAY.
  - Out of range: no register change and no wr_pulse. bresp = SLVERR.
- W_RESP: bvalid is high until bready, then the FSM returns to W_IDLE. awready and wready are low throughout W_RESP.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE, arready = 1. On the AR handshake, rdata is captured from reg_out[i], or from reg_in[i] if RO_MASK[i] = 1, and the FSM moves to R_DATA.
  - Out of range: rdata = 0 and rresp = SLVERR.
  - rd_pulse[i] is high for one cycle after an in-range AR handshake.
- R_DATA: rvalid is high with rdata and rresp stable until rready, then the FSM returns to R_IDLE.
- Read and write FSMs are independent. A read accepted on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset (asynchronous assert, synchronous release): reg_out = 0, all valid outputs = 0, wr_pulse = rd_pulse = 0, held AW/W discarded, both FSMs in IDLE.
- awready, wready and arready are 1 in the first cycle after reset release.
- A reset during an outstanding transaction drops it with no response.
- Write latency: AW and W handshaking together at edge N gives reg_out updated, wr_pulse and bvalid high after edge N. Maximum rate is one write per 2 cycles with bready tied high.
- Read latency: AR handshake at edge N gives rvalid and rd_pulse high after edge N. Maximum rate is one read per 2 cycles.
- No combinational path from any input to any ready or valid output, except that valid outputs drop on the cycle following the ready handshake edge.

## Structure
- Package axi_regfile_pkg contains:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}
  - function strb_merge(old, new, strb)
- Single module. The write and read FSMs are separate always_ff blocks. No sub-module is needed.
- Top-level integration: software-visible constants (for example a 0xDEADBEEF ID) are set by tying reg_in with RO_MASK set for that register.

## Test plan
- Defaults, reset release, write 0x12345678 to byte address 0x08 with AW and W in the same cycle -> reg_out[2] = 0x12345678, wr_pulse[2] high for one cycle, bresp = OKAY one cycle after the handshake.
- W sent 3 cycles before AW, wstrb = 4'b0101, data 0xAABBCCDD onto 0x12345678 -> reg_out[2] = 0x12BB56DD, single bvalid.
- RO_MASK[0] = 1, reg_in[0] = 0xDEADBEEF; write 0 to address 0x00 then read -> bresp OKAY, rdata = 0xDEADBEEF, rd_pulse[0] pulses, no wr_pulse[0].
- Read and write to address 0x40 with NREG = 16 -> bresp = SLVERR, rresp = SLVERR, rdata = 0, no register changes.
- bready and rready held low for 10 cycles -> bvalid, rvalid and data stay stable; awready and wready stay low; no second write accepted.
- Assert axi_aresetn low mid-response with reg_out[5] = 0xFFFFFFFF -> bvalid drops immediately, reg_out[5] = 0, next write completes normally.

Source files
------------

// File: rtl/axi_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
package axi_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Works on the widest supported word; callers truncate to DATA_W.
  function automatic logic [63:0] strb_merge(
    input logic [63:0] old_v,
    input logic [63:0] new_v,
    input logic [7:0]  strb
  );
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_regfile_param.sv
// AXI4-Lite slave register file with byte strobes, decode errors,
// per-register read-back select and one-cycle access pulses.
module axi_regfile_param
  import axi_regfile_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic [ADDR_W-1:0]      s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_W-1:0]      s_axi_wdata,
  input  logic [DATA_W/8-1:0]    s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_W-1:0]      s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [DATA_W-1:0]      s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [NREG*DATA_W-1:0] reg_out,
  input  logic [NREG*DATA_W-1:0] reg_in,
  output logic [NREG-1:0]        wr_pulse,
  output logic [NREG-1:0]        rd_pulse
);

  localparam int SB   = DATA_W / 8;
  localparam int OFFS = $clog2(SB);
  localparam int IW   = ADDR_W - OFFS;
  localparam logic [IW:0] NREG_V = (IW+1)'(NREG);

  logic [DATA_W-1:0] regs_q [NREG];

  wr_state_t         wst_q, wst_d;
  logic              aw_held_q, w_held_q;
  logic [IW-1:0]     awidx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SB-1:0]     wstrb_q;
  logic [1:0]        bresp_q;
  logic [NREG-1:0]   wr_pulse_q;

  rd_state_t         rst_q, rst_d;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [NREG-1:0]   rd_pulse_q;

  logic              aw_hs, w_hs, commit;
  logic [IW-1:0]     w_idx;
  logic              w_in;
  logic [DATA_W-1:0] wdata_c;
  logic [SB-1:0]     wstrb_c;
  logic              ar_hs;
  logic [IW-1:0]     r_idx;
  logic              r_in;
  logic [DATA_W-1:0] rd_word;
  logic [NREG-1:0]   rd_sel;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[OFFS-1:0],
                              s_axi_araddr[OFFS-1:0]};

  assign s_axi_awready = (wst_q == W_IDLE) && !aw_held_q;
  assign s_axi_wready  = (wst_q == W_IDLE) && !w_held_q;
  assign s_axi_bvalid  = (wst_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign wr_pulse      = wr_pulse_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  // Held beats take priority; a fresh handshake fills the missing half.
  assign w_idx   = aw_held_q ? awidx_q : s_axi_awaddr[ADDR_W-1:OFFS];
  assign wdata_c = w_held_q ? wdata_q : s_axi_wdata;
  assign wstrb_c = w_held_q ? wstrb_q : s_axi_wstrb;
  assign w_in    = {1'b0, w_idx} < NREG_V;
  assign commit  = (wst_q == W_IDLE) &&
                   (aw_held_q || aw_hs) && (w_held_q || w_hs);

  always_comb begin
    wst_d = wst_q;
    unique case (wst_q)
      W_IDLE: if (commit) wst_d = W_RESP;
      W_RESP: if (s_axi_bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wst_q      <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      wst_q      <= wst_d;
      wr_pulse_q <= '0;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awidx_q   <= s_axi_awaddr[ADDR_W-1:OFFS];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axi_wdata;
        wstrb_q  <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= w_in ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NREG; i++) begin
          if (w_in && w_idx == IW'(i) && !RO_MASK[i]) begin
            regs_q[i]     <= DATA_W'(strb_merge(64'(regs_q[i]),
                                                64'(wdata_c),
                                                8'(wstrb_c)));
            wr_pulse_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign s_axi_arready = (rst_q == R_IDLE);
  assign s_axi_rvalid  = (rst_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign rd_pulse      = rd_pulse_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_idx = s_axi_araddr[ADDR_W-1:OFFS];
  assign r_in  = {1'b0, r_idx} < NREG_V;

  always_comb begin
    rd_word = '0;
    rd_sel  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_idx == IW'(i)) begin
        rd_sel[i] = 1'b1;
        rd_word   = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
  end

  always_comb begin
    rst_d = rst_q;
    unique case (rst_q)
      R_IDLE: if (s_axi_arvalid) rst_d = R_DATA;
      R_DATA: if (s_axi_rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rst_q      <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      rst_q      <= rst_d;
      rd_pulse_q <= '0;
      if (ar_hs) begin
        rdata_q    <= r_in ? rd_word : '0;
        rresp_q    <= r_in ? RESP_OKAY : RESP_SLVERR;
        rd_pulse_q <= r_in ? rd_sel : '0;
      end
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_out
    assign reg_out[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

endmodule
